sys_rx_cmd_decoder: RTL and testbench

//  Consumes bytes from the RX data synchroniser: sync_bus with its one-cycle enable pulse, in the system clock domain.

---
 rtl/sys_rx_cmd_decoder_if.sv | 31 +++
 rtl/sys_rx_cmd_decoder.sv | 169 ++++++++++++++++
 tb/tb_sys_rx_cmd_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sys_rx_cmd_decoder_if.sv
// Byte-in / register-file + ALU command-out bundle for the RX command decoder.
// rx_valid is a one-cycle strobe qualifying rx_data; there is no ready, the decoder accepts every byte.
interface sys_rx_cmd_decoder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rf_wr_en;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              alu_en;
  logic [3:0]        alu_fun;
  logic              clk_gate_en;
  logic              busy;
  logic              frame_err;
  logic [2:0]        dbg_state;

  modport slave (
    input  rx_data, rx_valid,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, busy, frame_err, dbg_state
  );

  modport master (
    output rx_data, rx_valid,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, busy, frame_err, dbg_state
  );
endinterface

// File: rtl/sys_rx_cmd_decoder.sv
// RX command decoder: parses synchronised bytes into reg-file write/read and ALU frames.
// All outputs are registered; unknown opcodes and stalled frames are dropped with a frame_err pulse.
module sys_rx_cmd_decoder #(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 4,
  parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
  parameter int              TIMEOUT_CYC = 1024
) (
  input logic                  dest_clk,
  input logic                  dest_rst,
  sys_rx_cmd_decoder_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_ALU_A   = 3'd4,
    S_ALU_B   = 3'd5,
    S_ALU_FUN = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              alu_en_q, alu_en_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic              clk_gate_en_q, clk_gate_en_d;
  logic              frame_err_q, frame_err_d;

  logic expire;
  logic op_alu;
  logic op_known;

  // A byte on the expiry cycle wins, so expiry requires rx_valid low.
  assign expire   = (TIMEOUT_CYC > 0) && (state_q != S_IDLE) && !bus.rx_valid &&
                    (cnt_q == CNT_MAX);
  assign op_alu   = (bus.rx_data == CMD_ALU_OP) || (bus.rx_data == CMD_ALU_NOP);
  assign op_known = op_alu || (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);

  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((TIMEOUT_CYC == 0) || (state_q == S_IDLE) || bus.rx_valid) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expire) begin
      state_d = S_IDLE;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if      (bus.rx_data == CMD_WR)      state_d = S_WR_ADDR;
          else if (bus.rx_data == CMD_RD)      state_d = S_RD_ADDR;
          else if (bus.rx_data == CMD_ALU_OP)  state_d = S_ALU_A;
          else if (bus.rx_data == CMD_ALU_NOP) state_d = S_ALU_FUN;
          else                                 state_d = S_IDLE;
        end
        S_WR_ADDR: state_d = S_WR_DATA;
        S_ALU_A:   state_d = S_ALU_B;
        S_ALU_B:   state_d = S_ALU_FUN;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    frame_err_d   = 1'b0;
    clk_gate_en_d = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    alu_fun_d     = alu_fun_q;
    if (expire) begin
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_valid) begin
            clk_gate_en_d = op_alu;
            frame_err_d   = !op_known;
          end
        end
        S_WR_ADDR: begin
          if (bus.rx_valid) rf_addr_d = bus.rx_data[ADDR_W-1:0];
        end
        S_WR_DATA: begin
          if (bus.rx_valid) begin
            rf_wr_data_d = bus.rx_data;
            rf_wr_en_d   = 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (bus.rx_valid) begin
            rf_addr_d  = bus.rx_data[ADDR_W-1:0];
            rf_rd_en_d = 1'b1;
          end
        end
        S_ALU_A, S_ALU_B: begin
          clk_gate_en_d = 1'b1;
          if (bus.rx_valid) begin
            rf_addr_d    = (state_q == S_ALU_A) ? ADDR_W'(0) : ADDR_W'(1);
            rf_wr_data_d = bus.rx_data;
            rf_wr_en_d   = 1'b1;
          end
        end
        S_ALU_FUN: begin
          // Gate stays open through the alu_en cycle, closing one cycle later from IDLE.
          clk_gate_en_d = 1'b1;
          if (bus.rx_valid) begin
            alu_fun_d = bus.rx_data[3:0];
            alu_en_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_sys_rx_cmd_decoder.sv
// Directed bench for sys_rx_cmd_decoder: expected strobe events go into exp_q,
// a negedge monitor pops and compares each strobe the decoder presents.
module tb_sys_rx_cmd_decoder;
  localparam int TIMEOUT_CYC = 1024;
  localparam int W = 18;
  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ALU = 2'd2, K_ERR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_q[$];

  sys_rx_cmd_decoder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sys_rx_cmd_decoder #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .dest_clk (clk),
    .dest_rst (rst),
    .bus      (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(logic [1:0] kind, logic [3:0] addr,
                                        logic [7:0] data, logic [3:0] fun);
    return {kind, addr, data, fun};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: always entered and left on a negedge
  task automatic send_byte(logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_wr(logic [3:0] a, logic [7:0] d); exp_q.push_back(pack(K_WR, a, d, 4'h0)); endtask
  task automatic exp_rd(logic [3:0] a);                exp_q.push_back(pack(K_RD, a, 8'h00, 4'h0)); endtask
  task automatic exp_alu(logic [3:0] f);               exp_q.push_back(pack(K_ALU, 4'h0, 8'h00, f)); endtask
  task automatic exp_err();                            exp_q.push_back(pack(K_ERR, 4'h0, 8'h00, 4'h0)); endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      int nstrobe;
      logic [W-1:0] act;
      nstrobe = int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) + int'(bus.frame_err);
      if (nstrobe > 1) check("one_strobe", nstrobe, 1);
      if (nstrobe != 0) begin
        if      (bus.rf_wr_en) act = pack(K_WR, bus.rf_addr, bus.rf_wr_data, 4'h0);
        else if (bus.rf_rd_en) act = pack(K_RD, bus.rf_addr, 8'h00, 4'h0);
        else if (bus.alu_en)   act = pack(K_ALU, 4'h0, 8'h00, bus.alu_fun);
        else                   act = pack(K_ERR, 4'h0, 8'h00, 4'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", act, '1);
        end else begin
          check("strobe_event", act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    check("rst_wr_en", bus.rf_wr_en, 0);
    check("rst_rd_en", bus.rf_rd_en, 0);
    check("rst_alu_en", bus.alu_en, 0);
    check("rst_addr", bus.rf_addr, 0);
    check("rst_wdata", bus.rf_wr_data, 0);
    check("rst_fun", bus.alu_fun, 0);
    check("rst_gate", bus.clk_gate_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.frame_err, 0);
    rst = 1'b0;
    idle(2);

    // write frame, strobe one cycle after the third byte
    exp_wr(4'h5, 8'h3C);
    send_byte(8'hAA); check("wr_busy", bus.busy, 1);
    send_byte(8'h05); idle(3);
    send_byte(8'h3C);
    check("wr_latency", bus.rf_wr_en, 1);
    check("wr_busy_done", bus.busy, 0);
    idle(1);
    check("wr_pulse_width", bus.rf_wr_en, 0);

    // read frame, then write with upper address bits ignored
    exp_rd(4'hF);
    send_byte(8'hBB); send_byte(8'h0F);
    check("rd_latency", bus.rf_rd_en, 1);
    idle(2);
    exp_wr(4'h2, 8'h00);
    send_byte(8'hAA); send_byte(8'h12); send_byte(8'h00);
    idle(2);

    // opcode values mid-frame are plain data
    exp_wr(4'hB, 8'hCC);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("data_not_opcode_busy", bus.busy, 0);
    idle(2);

    // ALU frame with operands and clock-gate window
    check("gate_idle", bus.clk_gate_en, 0);
    exp_wr(4'h0, 8'h07); exp_wr(4'h1, 8'h09); exp_alu(4'h2);
    send_byte(8'hCC);
    check("gate_rise", bus.clk_gate_en, 1);
    check("alu_busy", bus.busy, 1);
    send_byte(8'h07); idle(1);
    send_byte(8'h09);
    check("gate_mid", bus.clk_gate_en, 1);
    send_byte(8'h02);
    check("alu_latency", bus.alu_en, 1);
    check("gate_alu_cycle", bus.clk_gate_en, 1);
    idle(1);
    check("gate_fall", bus.clk_gate_en, 0);
    idle(1);

    // ALU no-operand frames, fun upper bits ignored
    exp_alu(4'h3);
    send_byte(8'hDD); send_byte(8'h03);
    idle(1);
    exp_alu(4'h5);
    send_byte(8'hDD); send_byte(8'hF5);
    idle(2);

    // unknown opcode
    exp_err();
    send_byte(8'h5A);
    check("bad_op_err", bus.frame_err, 1);
    check("bad_op_busy", bus.busy, 0);
    idle(2);

    // inter-byte timeout drops the frame
    exp_err();
    send_byte(8'hAA); send_byte(8'h01);
    idle(TIMEOUT_CYC - 1);
    check("to_not_early_busy", bus.busy, 1);
    check("to_not_early_err", bus.frame_err, 0);
    idle(1);
    check("to_err", bus.frame_err, 1);
    check("to_idle", bus.busy, 0);
    idle(2);

    // byte on the expiry cycle wins
    exp_wr(4'h1, 8'h3C);
    send_byte(8'hAA); send_byte(8'h01);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h3C);
    check("race_wr", bus.rf_wr_en, 1);
    check("race_no_err", bus.frame_err, 0);
    idle(2);

    // reset mid ALU frame
    exp_wr(4'h0, 8'h07);
    send_byte(8'hCC); send_byte(8'h07);
    idle(1);
    check("pre_rst_gate", bus.clk_gate_en, 1);
    rst = 1'b1;
    idle(2);
    check("mid_rst_gate", bus.clk_gate_en, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_state", bus.dbg_state, 0);
    check("mid_rst_addr", bus.rf_addr, 0);
    rst = 1'b0;
    idle(1);
    exp_alu(4'h1);
    send_byte(8'hDD); send_byte(8'h01);
    check("post_rst_alu", bus.alu_en, 1);
    idle(5);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
